// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types, constants and length clamp for seq_pattern_tx
package seq_pkg;

  // Frame sequencer states; PAR is only reachable when parity is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Default pattern word width, also the longest frame in bits.
  localparam int SEQ_DATA_W = 8;

  // Effective frame length: 0 selects the full word, oversize requests saturate.
  function automatic int seq_clamp_len(input logic [3:0] len, input int data_w);
    int l;
    l = int'({28'd0, len});
    if (l == 0 || l > data_w) begin
      return data_w;
    end
    return l;
  endfunction

endpackage

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - MSB-first serial pattern transmitter, optional parity via SEQ_PATTERN_TX_PARITY_EN
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        len,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              busy,
  output logic              done
);

  // Counter holds the full effective length (up to DATA_W) without wrapping.
  localparam int CW = $clog2(DATA_W) + 1;

  seq_state_t        state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              tx_bit_n;
  logic              tx_valid_n;
  logic              busy_n;
  logic              done_n;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic              par, par_n;
`endif

  // Next-state, datapath and registered-output values; outputs lag the state by one edge.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    cnt_n      = cnt;
    tx_bit_n   = 1'b0;
    tx_valid_n = 1'b0;
    done_n     = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    par_n      = par;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SHIFT;
          shreg_n = data;
          cnt_n   = CW'(seq_clamp_len(len, DATA_W));
`ifdef SEQ_PATTERN_TX_PARITY_EN
          par_n   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        tx_bit_n   = shreg[DATA_W-1];
        tx_valid_n = 1'b1;
        shreg_n    = shreg << 1;
        cnt_n      = cnt - CW'(1);
`ifdef SEQ_PATTERN_TX_PARITY_EN
        par_n      = par ^ shreg[DATA_W-1];
        if (cnt == CW'(1)) begin
          state_n = PAR;
        end
`else
        if (cnt == CW'(1)) begin
          state_n = DONE;
        end
`endif
      end
`ifdef SEQ_PATTERN_TX_PARITY_EN
      PAR: begin
        // par already folds in every data bit, so it is the even-parity bit itself.
        tx_bit_n   = par;
        tx_valid_n = 1'b1;
        state_n    = DONE;
      end
`endif
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n == SHIFT) || (state_n == PAR);
  end

  // State and output registers; synchronous reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      tx_bit   <= 1'b0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      cnt      <= cnt_n;
      tx_bit   <= tx_bit_n;
      tx_valid <= tx_valid_n;
      busy     <= busy_n;
      done     <= done_n;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end

endmodule
